// File: rtl/imm_gen_pipe_pkg.sv
// Shared format codes and buffer depth for the immediate-generator pipeline.
// Purely declarative: no logic, no latency.
// Backpressure: not applicable.
package imm_gen_pipe_pkg;

    // Instruction format codes carried on in_type
    localparam logic [4:0] INST_R  = 5'd0;
    localparam logic [4:0] INST_I  = 5'd1;
    localparam logic [4:0] INST_S  = 5'd2;
    localparam logic [4:0] INST_B  = 5'd3;
    localparam logic [4:0] INST_U  = 5'd4;
    localparam logic [4:0] INST_J  = 5'd5;
    localparam logic [4:0] INST_CI = 5'd6;
    localparam logic [4:0] INST_CJ = 5'd7;
    localparam logic [4:0] INST_CB = 5'd8;

    // Skid buffer holds two results so a registered in_ready never loses data
    localparam int IMM_FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_gen_pipe_fmt_decode.sv
// Combinational {inst,type,shift} -> {sign-extended immediate, unknown-format flag}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; AURORA_IMM_RVC_EN adds the CI/CJ/CB compressed formats.
module imm_fmt_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [4:0]      fmt,
    input  logic            shift,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Low opcode bits never feed an immediate; keep them visibly consumed
    logic unused_opc;
    assign unused_opc = ^inst[1:0];

    // Select and sign-extend the immediate field for the given format
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (fmt)
            INST_R: begin
                // Register-register ops carry no immediate
                imm = '0;
            end
            INST_I: begin
                if (shift) begin
                    // RV32 shamt is 5 bits; inst[25] is ignored there
                    if (XLEN == 64) imm = XLEN'(inst[25:20]);
                    else            imm = XLEN'(inst[24:20]);
                end else begin
                    imm = XLEN'($signed(inst[31:20]));
                end
            end
            INST_S: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            INST_B: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            INST_U: imm = XLEN'($signed({inst[31:12], 12'b0}));
            INST_J: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
`ifdef AURORA_IMM_RVC_EN
            INST_CI: imm = XLEN'($signed({inst[12], inst[6:2]}));
            INST_CJ: imm = XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                           inst[2], inst[11], inst[5:3], 1'b0}));
            INST_CB: imm = XLEN'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                                           inst[4:3], 1'b0}));
`endif
            default: begin
                // Unrecognised or disabled format: flag it, immediate forced to zero
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on input, then a 2-entry skid FIFO driving out_*.
// Latency: 1 cycle from accept to out_valid; 1 result/cycle when out_ready=1.
// Backpressure: in_ready registered, low only when both entries are held (AURORA_IMM_RVC_EN enables RVC).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [4:0]       in_type,
    input  logic             in_shift,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic [XLEN-1:0]  imm_q [IMM_FIFO_DEPTH];
    logic [XLEN-1:0]  imm_d [IMM_FIFO_DEPTH];
    logic             err_q [IMM_FIFO_DEPTH];
    logic             err_d [IMM_FIFO_DEPTH];
    logic [TAG_W-1:0] tag_q [IMM_FIFO_DEPTH];
    logic [TAG_W-1:0] tag_d [IMM_FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;

    imm_fmt_decode #(
        .XLEN (XLEN)
    ) u_fmt_decode (
        .inst  (in_inst),
        .fmt   (in_type),
        .shift (in_shift),
        .imm   (dec_imm),
        .err   (dec_err)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_imm   = imm_q[rd_ptr_q];
    assign out_err   = err_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // FIFO write/read pointers, occupancy and the registered ready
    always_comb begin
        imm_d    = imm_q;
        err_d    = err_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            imm_d[wr_ptr_q] = dec_imm;
            err_d[wr_ptr_q] = dec_err;
            tag_d[wr_ptr_q] = in_tag;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // push is impossible while full because in_ready_q is already low
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (cnt_d != 2'(IMM_FIFO_DEPTH));
    end

    // State registers; reset discards all buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q      <= '{default: '0};
            err_q      <= '{default: 1'b0};
            tag_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            imm_q      <= imm_d;
            err_q      <= err_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven in lockstep.
// Directed cases plus randomized traffic against a queue-based reference model.
// Backpressure exercised via random out_ready and mid-stream resets.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [4:0]       in_type;
    logic             in_shift;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             rdy32, vld32, err32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64, vld64, err64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_type(in_type), .in_shift(in_shift), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_err(err32),
        .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_type(in_type), .in_shift(in_shift), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_err(err64),
        .out_tag(tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      imm32;
        logic [63:0]      imm64;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             model_q[$];
    logic [TAG_W-1:0] popped[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               acc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic longint sext(input longint val, input int n);
        if (val[n-1]) return val - (64'sd1 <<< n);
        return val;
    endfunction

    // Reference: immediates computed from field definitions with plain arithmetic
    function automatic void ref_imm(input logic [31:0] inst, input logic [4:0] ty, input logic sh,
                                    input bit x64, output logic [63:0] imm, output logic err);
        longint v = 0;
        err = 1'b0;
        if (ty == INST_I && sh)      v = x64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
        else if (ty == INST_I)       v = sext(longint'(inst[31:20]), 12);
        else if (ty == INST_S)       v = sext(longint'({inst[31:25], inst[11:7]}), 12);
        else if (ty == INST_B)       v = sext(longint'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2, 13);
        else if (ty == INST_U)       v = sext(longint'(inst[31:12]) * 4096, 32);
        else if (ty == INST_J)       v = sext(longint'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2, 21);
`ifdef AURORA_IMM_RVC_EN
        else if (ty == INST_CI)      v = sext(longint'({inst[12], inst[6:2]}), 6);
        else if (ty == INST_CJ)      v = sext(longint'({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                                        inst[2], inst[11], inst[5:3]}) * 2, 12);
        else if (ty == INST_CB)      v = sext(longint'({inst[12], inst[6:5], inst[2], inst[11:10],
                                                        inst[4:3]}) * 2, 9);
`endif
        else if (ty == INST_R)       v = 0;
        else                         err = 1'b1;
        imm = x64 ? 64'(v) : {32'b0, 32'(v)};
    endfunction

    // One clock: score the handshakes the DUTs will see at this edge, then advance
    task automatic tick();
        exp_t e;
        logic [63:0] i32, i64;
        logic er;
        acc = 1'b0;
        if (rst) begin
            model_q.delete();
        end else begin
            chk("vld32", {63'b0, vld32}, {63'b0, model_q.size() != 0});
            chk("vld64", {63'b0, vld64}, {63'b0, model_q.size() != 0});
            chk("rdy32", {63'b0, rdy32}, {63'b0, model_q.size() < 2});
            chk("rdy64", {63'b0, rdy64}, {63'b0, model_q.size() < 2});
            if (vld32 && out_ready && model_q.size() != 0) begin
                e = model_q.pop_front();
                chk("imm32", {32'b0, imm32}, {32'b0, e.imm32});
                chk("imm64", imm64, e.imm64);
                chk("err32", {63'b0, err32}, {63'b0, e.err});
                chk("err64", {63'b0, err64}, {63'b0, e.err});
                chk("tag32", {56'b0, tag32}, {56'b0, e.tag});
                chk("tag64", {56'b0, tag64}, {56'b0, e.tag});
                popped.push_back(tag32);
            end
            if (in_valid && rdy32) begin
                ref_imm(in_inst, in_type, in_shift, 1'b0, i32, er);
                ref_imm(in_inst, in_type, in_shift, 1'b1, i64, er);
                e.imm32 = i32[31:0];
                e.imm64 = i64;
                e.err   = er;
                e.tag   = in_tag;
                model_q.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic [31:0] inst, input logic [4:0] ty, input logic sh,
                       input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_type  = ty;
        in_shift = sh;
        in_tag   = tag;
    endtask

    // Present one request and tick until accepted (bounded)
    task automatic send(input logic [31:0] inst, input logic [4:0] ty, input logic sh,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        drv(inst, ty, sh, tag);
        do begin
            tick();
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (model_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (model_q.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_type = INST_I; in_shift = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_vld",  {63'b0, vld32}, 64'd0);
        chk("rst_rdy",  {63'b0, rdy32}, 64'd1);
        chk("rst_imm",  imm64, 64'd0);
        chk("rst_err",  {63'b0, err64}, 64'd0);
        chk("rst_tag",  {56'b0, tag32}, 64'd0);

        // addi x1,x0,-1
        send(32'hFFF00093, INST_I, 1'b0, 8'h11);
        chk("t1_vld", {63'b0, vld32}, 64'd1);
        chk("t1_imm32", {32'b0, imm32}, {32'b0, 32'hFFFFFFFF});
        chk("t1_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
        chk("t1_err", {63'b0, err32}, 64'd0);
        drain();

        // Shift immediate width per XLEN
        send(32'h03F09093, INST_I, 1'b1, 8'h22);
        chk("t2_shamt64", imm64, 64'd63);
        chk("t2_shamt32", {32'b0, imm32}, 64'd31);
        drain();

        // beq x0,x0,-4 and lui
        send(32'hFE000EE3, INST_B, 1'b0, 8'h33);
        chk("t3_b32", {32'b0, imm32}, {32'b0, 32'hFFFFFFFC});
        chk("t3_b64", imm64, 64'hFFFFFFFF_FFFFFFFC);
        drain();
        send(32'h12345037, INST_U, 1'b0, 8'h34);
        chk("t3_u32", {32'b0, imm32}, {32'b0, 32'h12345000});
        chk("t3_u64", imm64, 64'h00000000_12345000);
        drain();

        // Backpressure: three requests with out_ready low
        out_ready = 1'b0;
        popped.delete();
        drv(32'h00100093, INST_I, 1'b0, 8'd1); tick();
        drv(32'h00200093, INST_I, 1'b0, 8'd2); tick();
        drv(32'h00300093, INST_I, 1'b0, 8'd3);
        chk("t4_rdy_low", {63'b0, rdy32}, 64'd0);
        tick();
        tick();
        chk("t4_rdy_held", {63'b0, rdy32}, 64'd0);
        chk("t4_head_tag", {56'b0, tag32}, 64'd1);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!acc && n < 20) begin
                tick();
                n++;
            end
            if (!acc) chk("t4_accept_timeout", 64'd0, 64'd1);
        end
        drain();
        chk("t4_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("t4_order0", {56'b0, popped[0]}, 64'd1);
            chk("t4_order1", {56'b0, popped[1]}, 64'd2);
            chk("t4_order2", {56'b0, popped[2]}, 64'd3);
        end

        // Reset while two entries are held
        out_ready = 1'b0;
        send(32'h00500093, INST_I, 1'b0, 8'hA1);
        send(32'h00600093, INST_I, 1'b0, 8'hA2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_vld", {63'b0, vld32}, 64'd0);
        chk("t5_rdy", {63'b0, rdy32}, 64'd1);
        chk("t5_tag", {56'b0, tag32}, 64'd0);
        out_ready = 1'b1;
        popped.delete();
        send(32'h00700093, INST_I, 1'b0, 8'h55);
        drain();
        chk("t5_fresh_cnt", 64'(popped.size()), 64'd1);
        if (popped.size() == 1) chk("t5_fresh_tag", {56'b0, popped[0]}, 64'h55);

        // c.j -2
        send(32'h0000BFFD, INST_CJ, 1'b0, 8'h66);
`ifdef AURORA_IMM_RVC_EN
        chk("t6_cj_imm", imm64, 64'hFFFFFFFF_FFFFFFFE);
        chk("t6_cj_err", {63'b0, err64}, 64'd0);
`else
        chk("t6_cj_imm", imm64, 64'd0);
        chk("t6_cj_err", {63'b0, err64}, 64'd1);
`endif
        drain();

        // Randomized traffic with random backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] ty;
            ty = 5'($urandom_range(1, 12));
            rst       = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_inst   = $urandom;
            in_type   = ty;
            in_shift  = 1'($urandom_range(0, 1));
            in_tag    = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
